buzzer_sched: RTL and testbench

Request scheduler for the single buzzer in the vending design. Sits between event sources (coin accepted, item vended, error/refund) and `buzzer_ctrl`. Latches one-cycle request pulses, grants the buzzer to one tune at a time by fixed priority, and waits for `end_note` or a timeout. It then enforces a silent gap before the next tune.

---
 rtl/vending_pkg.sv | 37 +++
 rtl/buzzer_sched.sv | 131 +++++++++++++
 tb/tb_buzzer_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared constants for the vending design: buzzer tune codes, pending-flag
// indices and the buzzer scheduler state encoding.
package vending_pkg;

    localparam logic [1:0] TUNE_OFF  = 2'b00;
    localparam logic [1:0] TUNE_COIN = 2'b01;
    localparam logic [1:0] TUNE_VEND = 2'b10;
    localparam logic [1:0] TUNE_ERR  = 2'b11;

    localparam int PEND_COIN = 0;
    localparam int PEND_VEND = 1;
    localparam int PEND_ERR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    // Fixed priority: err > vend > coin.
    function automatic logic [1:0] pick_tune(input logic [2:0] pend);
        if (pend[PEND_ERR])       return TUNE_ERR;
        else if (pend[PEND_VEND]) return TUNE_VEND;
        else if (pend[PEND_COIN]) return TUNE_COIN;
        else                      return TUNE_OFF;
    endfunction

    function automatic logic [2:0] tune_mask(input logic [1:0] tune);
        case (tune)
            TUNE_COIN: return 3'b001;
            TUNE_VEND: return 3'b010;
            TUNE_ERR:  return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/buzzer_sched.sv
// Buzzer request scheduler: latches request pulses, grants one tune at a time
// by priority, ends it on end_note / timeout / err preemption, then holds a gap.
module buzzer_sched
    import vending_pkg::*;
#(
    parameter int TIMEOUT_CYC = 150_000_000,
    parameter int GAP_CYC     = 5_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_coin,
    input  logic         req_vend,
    input  logic         req_err,
    input  logic         mute,
    input  logic         end_note,
    output logic [1:0]   work_en,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output sched_state_e dbg_state
);

    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    sched_state_e     state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       work_q, work_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic             busy_q;

    logic [2:0] req_vec;
    logic [1:0] grant_tune;
    logic       start, play_end, play_tmo, play_pre, gap_end;

    assign req_vec    = {req_err, req_vend, req_coin};
    assign grant_tune = pick_tune(pend_q);
    assign start      = (state_q == ST_IDLE) && (pend_q != 3'b000);
    assign play_end   = (state_q == ST_PLAY) && end_note;
    assign play_tmo   = (state_q == ST_PLAY) && (cnt_q == TMO_LAST);
    assign play_pre   = (state_q == ST_PLAY) && pend_q[PEND_ERR] && (work_q != TUNE_ERR);
    assign gap_end    = (state_q == ST_GAP) && (cnt_q == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= 3'b000;
            cnt_q   <= '0;
            work_q  <= TUNE_OFF;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (mute) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_PLAY;
                ST_PLAY: if (play_end || play_tmo || play_pre) state_d = ST_GAP;
                ST_GAP:  if (gap_end) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A request on the same edge as its grant survives the clear and stays queued.
    always_comb begin
        work_d = work_q;
        done_d = 1'b0;
        tmo_d  = 1'b0;
        pend_d = pend_q | req_vec;
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (mute) begin
            work_d = TUNE_OFF;
            pend_d = 3'b000;
            cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (start) begin
                        work_d = grant_tune;
                        pend_d = (pend_q & ~tune_mask(grant_tune)) | req_vec;
                    end
                end
                ST_PLAY: begin
                    if (play_end) begin
                        work_d = TUNE_OFF;
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else if (play_tmo || play_pre) begin
                        work_d = TUNE_OFF;
                        tmo_d  = 1'b1;
                        cnt_d  = '0;
                    end
                end
                ST_GAP: begin
                    work_d = TUNE_OFF;
                    if (gap_end) cnt_d = '0;
                end
                default: begin
                    work_d = TUNE_OFF;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    assign work_en   = work_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = tmo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_buzzer_sched.sv
// Bench for buzzer_sched: directed scenarios and random traffic against a
// tune/age/gap-countdown reference model.
module tb_buzzer_sched;
    import vending_pkg::*;

    localparam int TMO = 20;
    localparam int GAP = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_coin = 1'b0, req_vend = 1'b0, req_err = 1'b0;
    logic         mute = 1'b0, end_note = 1'b0;
    logic [1:0]   work_en;
    logic         busy, done, timeout;
    sched_state_e dbg_state;

    always #5 clk = ~clk;

    buzzer_sched #(.TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_coin(req_coin), .req_vend(req_vend), .req_err(req_err),
        .mute(mute), .end_note(end_note),
        .work_en(work_en), .busy(busy), .done(done), .timeout(timeout),
        .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;
    logic [4:0] exp_q[$];

    // Model: tune playing (0 = none, 1 coin, 2 vend, 3 err), cycles played,
    // gap cycles still to wait, and the set of waiting requests.
    int m_tune, m_age, m_gap;
    bit m_pend[3];
    int coin_starts;
    logic [1:0] prev_work;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tune = 0; m_age = 0; m_gap = 0;
        for (int i = 0; i < 3; i++) m_pend[i] = 0;
        prev_work = TUNE_OFF;
    endtask

    task automatic model_step();
        bit old[3];
        bit m_done, m_tmo;
        int pick;
        m_done = 0; m_tmo = 0;
        for (int i = 0; i < 3; i++) old[i] = m_pend[i];
        if (mute) begin
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
            m_tune = 0; m_gap = 0;
        end else begin
            if (m_tune != 0) begin
                if (end_note) begin
                    m_done = 1; m_tune = 0; m_gap = GAP;
                end else if (m_age == TMO - 1 || (old[2] && m_tune != 3)) begin
                    m_tmo = 1; m_tune = 0; m_gap = GAP;
                end else begin
                    m_age++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                pick = -1;
                for (int i = 0; i < 3; i++) if (old[i]) pick = i;
                if (pick >= 0) begin
                    m_tune = pick + 1; m_pend[pick] = 0; m_age = 0;
                end
            end
            if (req_coin) m_pend[0] = 1;
            if (req_vend) m_pend[1] = 1;
            if (req_err)  m_pend[2] = 1;
        end
        exp_q.push_back({2'(m_tune), (m_tune != 0) || (m_gap > 0), m_done, m_tmo});
    endtask

    task automatic step(input logic c, input logic v, input logic e, input logic m, input logic en);
        logic [4:0] ex;
        req_coin = c; req_vend = v; req_err = e; mute = m; end_note = en;
        @(posedge clk);
        model_step();
        @(negedge clk);
        ex = exp_q.pop_front();
        chk("work_en", 32'(work_en), 32'(ex[4:3]));
        chk("busy", 32'(busy), 32'(ex[2]));
        chk("done", 32'(done), 32'(ex[1]));
        chk("timeout", 32'(timeout), 32'(ex[0]));
        if (prev_work != TUNE_COIN && work_en == TUNE_COIN) coin_starts++;
        prev_work = work_en;
        req_coin = 0; req_vend = 0; req_err = 0; mute = 0; end_note = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int k;
        model_reset();
        coin_starts = 0;
        #12;
        chk("rst_work", 32'(work_en), 32'(TUNE_OFF));
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tmo", 32'(timeout), 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Single coin tune ended by end_note, then the gap.
        idle(3);
        step(1, 0, 0, 0, 0);
        chk("s1_pend_only", 32'(work_en), 32'(TUNE_OFF));
        step(0, 0, 0, 0, 0);
        chk("s1_grant", 32'(work_en), 32'(TUNE_COIN));
        idle(3);
        step(0, 0, 0, 0, 1);
        chk("s1_done", 32'(done), 1);
        chk("s1_off", 32'(work_en), 32'(TUNE_OFF));
        idle(3);
        chk("s1_gap_busy", 32'(busy), 1);
        step(0, 0, 0, 0, 0);
        chk("s1_idle", 32'(busy), 0);

        // Coin and vend together: vend first, coin after the gap.
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s2_vend_first", 32'(work_en), 32'(TUNE_VEND));
        idle(3);
        step(0, 0, 0, 0, 1);
        idle(5);
        chk("s2_coin_next", 32'(work_en), 32'(TUNE_COIN));
        step(0, 0, 0, 0, 1);
        idle(6);

        // Err preempts a playing coin; coin is not replayed.
        step(1, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("s3_preempt_tmo", 32'(timeout), 1);
        chk("s3_preempt_off", 32'(work_en), 32'(TUNE_OFF));
        idle(5);
        chk("s3_err_plays", 32'(work_en), 32'(TUNE_ERR));
        step(0, 0, 0, 0, 1);
        idle(8);
        chk("s3_no_replay", 32'(work_en), 32'(TUNE_OFF));

        // Timeout latency, then a late end_note is ignored.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        k = 0;
        while (k < 40 && timeout !== 1'b1) begin
            step(0, 0, 0, 0, 0);
            k++;
        end
        chk("s4_tmo_latency", 32'(k), 32'(TMO));
        step(0, 0, 0, 0, 1);
        chk("s4_late_end", 32'(done), 0);
        idle(6);

        // Repeated coin pulses while vend plays coalesce into one tune.
        coin_starts = 0;
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        idle(8);
        step(0, 0, 0, 0, 1);
        idle(8);
        chk("s5_one_coin", 32'(coin_starts), 1);

        // end_note with err pending in the same cycle: done wins.
        step(1, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("s6_done_wins", 32'(done), 1);
        chk("s6_no_tmo", 32'(timeout), 0);
        idle(5);
        chk("s6_err_after", 32'(work_en), 32'(TUNE_ERR));
        step(0, 0, 0, 0, 1);
        idle(6);

        // Request on the grant edge stays queued.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        idle(5);
        chk("s7_requeued", 32'(work_en), 32'(TUNE_COIN));
        step(0, 0, 0, 0, 1);
        idle(6);

        // Mute mid-tune with vend pending.
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("s8_mute_off", 32'(work_en), 32'(TUNE_OFF));
        chk("s8_mute_busy", 32'(busy), 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        idle(8);
        chk("s8_silent", 32'(work_en), 32'(TUNE_OFF));

        // Asynchronous reset mid-tune.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("s9_arst_work", 32'(work_en), 32'(TUNE_OFF));
        chk("s9_arst_busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 23) == 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
